// File: rtl/kim_if_fetch_unit.sv
// Instruction fetch unit: REQ/WAIT/HOLD/DROP sequencer feeding the IF/ID register.
// Optional fetch-timeout watchdog is built only when KIM_IF_FETCH_TIMEOUT_EN is defined.
module kim_if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instruction,
    output logic [31:0] pc_next_out,
    output logic        fetch_valid,
    output logic        is_flush,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcn_q, pcn_d;
    logic        valid_q, valid_d;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_inc;
    logic        present;
    logic [31:0] present_word;

    assign redirect_tgt = redirect_pc & ~32'd3;
    assign pc_inc       = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        instr_d      = '0;
        pcn_d        = pcn_q;
        valid_d      = 1'b0;
        present      = 1'b0;
        present_word = '0;
        case (state_q)
            S_REQ: begin
                if (redirect_en) begin
                    pc_d    = redirect_tgt;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_en) begin
                    pc_d    = redirect_tgt;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    if (stall) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        present      = 1'b1;
                        present_word = imem_rdata;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_en) begin
                    pc_d    = redirect_tgt;
                    hold_d  = '0;
                    state_d = S_REQ;
                end else if (!stall) begin
                    present      = 1'b1;
                    present_word = hold_q;
                end
            end
            default: begin
                // redirect while draining keeps draining the old outstanding response
                if (redirect_en) begin
                    pc_d = redirect_tgt;
                end else if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
        endcase
        if (present) begin
            instr_d = present_word;
            pcn_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            state_d = S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            instr_q <= '0;
            pcn_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pcn_q   <= pcn_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = rstn && (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc_next_out = pcn_q;
    assign fetch_valid = valid_q;
    assign is_flush    = redirect_en;

`ifdef KIM_IF_FETCH_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       waiting;

    always_comb begin
        waiting = ((state_q == S_WAIT) || (state_q == S_DROP)) &&
                  (state_d == state_q) && !imem_rvalid;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (waiting && ((cnt_q + 8'd1) == TIMEOUT_CYC)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_kim_if_fetch_unit.sv
// Directed bench for kim_if_fetch_unit: per-cycle model comparison plus literal pins.
module tb_kim_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instruction;
    logic [31:0] pc_next_out;
    logic        fetch_valid;
    logic        is_flush;
    logic        fetch_err;

    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = '0;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_instruction;
    logic [31:0] w_pcn;
    logic        w_fetch_valid;
    logic        w_is_flush;
    logic        w_fetch_err;

    always #5 clk = ~clk;

    kim_if_fetch_unit dut (
        .clk(clk), .rstn(rstn), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .instruction(instruction),
        .pc_next_out(pc_next_out), .fetch_valid(fetch_valid), .is_flush(is_flush),
        .fetch_err(fetch_err)
    );

    kim_if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rstn(rstn), .stall(w_zero), .redirect_en(w_zero),
        .redirect_pc(w_zero32), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .instruction(w_instruction),
        .pc_next_out(w_pcn), .fetch_valid(w_fetch_valid), .is_flush(w_is_flush),
        .fetch_err(w_fetch_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: phase 0 = issue request, 1 = awaiting word, 2 = holding word, 3 = discarding
    int          m_ph;
    logic [31:0] m_pc, m_hold, m_instr, m_pcn;
    logic        m_valid, m_err;
    int          m_cnt;

    task automatic model_reset();
        m_ph = 0; m_pc = 32'h0; m_hold = 0; m_instr = 0; m_pcn = 0;
        m_valid = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic rv, input logic [31:0] rdat);
        int          nph;
        logic        give;
        logic [31:0] w;
        nph = m_ph; give = 0; w = 0;
        m_valid = 0; m_instr = 0;
        if (rd) begin
            m_pc = {rpc[31:2], 2'b00};
            if (m_ph == 0 || m_ph == 3) nph = 3;
            else if (m_ph == 1) nph = rv ? 0 : 3;
            else begin nph = 0; m_hold = 0; end
        end else if (m_ph == 0) nph = 1;
        else if (m_ph == 1 && rv) begin
            if (st) begin m_hold = rdat; nph = 2; end
            else begin give = 1; w = rdat; end
        end else if (m_ph == 2 && !st) begin give = 1; w = m_hold; end
        else if (m_ph == 3 && rv) nph = 0;
        if (give) begin
            m_instr = w; m_pc = m_pc + 32'd4; m_pcn = m_pc; m_valid = 1; nph = 0;
        end
`ifdef KIM_IF_FETCH_TIMEOUT_EN
        if (nph != m_ph) m_cnt = 0;
        else if ((m_ph == 1 || m_ph == 3) && !rv) begin
            m_cnt++;
            if (m_cnt == 255) m_err = 1;
        end
`endif
        m_ph = nph;
    endtask

    // Memory and bookkeeping
    logic        mp_valid = 0;
    logic [31:0] mp_addr = 0;
    int          mp_wait = 0;
    int          mem_lat = 0;
    bit          mem_silent = 0;
    bit          force_rv = 0;
    logic        rst_drv = 0;
    logic        w_pend = 0;
    logic [31:0] w_pend_addr = 0;
    logic [31:0] vlog_i[$], vlog_p[$], alog[$];
    int          req_count = 0;
    int          w_valid_n = 0, w_req_n = 0;
    logic [31:0] w_first_pcn = 32'hFFFF_FFFF;
    logic [31:0] w_second_addr = 32'hFFFF_FFFF;

    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        rstn = rst_drv;
        stall = st; redirect_en = rd; redirect_pc = rpc;
        imem_rvalid = 0; imem_rdata = '0;
        if (force_rv) begin
            imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; force_rv = 0;
        end else if (mp_valid && !mem_silent) begin
            if (mp_wait == 0) begin
                imem_rvalid = 1; imem_rdata = 32'h1111_0000 + mp_addr; mp_valid = 0;
            end else mp_wait--;
        end
        w_rvalid = w_pend; w_rdata = 32'h2222_0000 + w_pend_addr;
        #2;
        if (!rstn) model_reset();
        chk("imem_req", imem_req, (m_ph == 0) && rstn);
        if (m_ph == 0 && rstn) chk("imem_addr", imem_addr, m_pc);
        chk("fetch_valid", fetch_valid, m_valid);
        chk("instruction", instruction, m_instr);
        chk("pc_next_out", pc_next_out, m_pcn);
        chk("is_flush", is_flush, rd);
        chk("fetch_err", fetch_err, m_err);
        if (fetch_valid) begin vlog_i.push_back(instruction); vlog_p.push_back(pc_next_out); end
        if (imem_req) begin alog.push_back(imem_addr); req_count++; end
        if (w_fetch_valid) begin
            if (w_valid_n == 0) w_first_pcn = w_pcn;
            w_valid_n++;
        end
        if (w_imem_req) begin
            if (w_req_n == 1) w_second_addr = w_imem_addr;
            w_req_n++;
        end
        if (rstn) model_step(st, rd, rpc, imem_rvalid, imem_rdata);
        if (!rstn) mp_valid = 0;
        else if (imem_req && !mem_silent) begin
            mp_valid = 1; mp_addr = imem_addr; mp_wait = mem_lat;
        end
        w_pend = rstn && w_imem_req; w_pend_addr = w_imem_addr;
    endtask

    initial begin
        int req_before, a_before, v_before, k, pre_err;
        model_reset();
        rst_drv = 0;
        repeat (3) tick(0, 0, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_pcn", pc_next_out, 0);
        chk("rst_valid", fetch_valid, 0);

        rst_drv = 1;
        repeat (7) tick(0, 0, 0);
        chk("seq_valid_count", vlog_i.size(), 3);
        chk("seq_addr0", alog[0], 32'h0);
        chk("seq_addr1", alog[1], 32'h4);
        chk("seq_addr2", alog[2], 32'h8);
        chk("seq_instr0", vlog_i[0], 32'h1111_0000);
        chk("seq_instr1", vlog_i[1], 32'h1111_0004);
        chk("seq_instr2", vlog_i[2], 32'h1111_0008);
        chk("seq_pcn0", vlog_p[0], 32'h4);
        chk("seq_pcn1", vlog_p[1], 32'h8);
        chk("seq_pcn2", vlog_p[2], 32'hC);

        req_before = req_count;
        repeat (4) tick(1, 0, 0);
        tick(0, 0, 0);
        chk("stall_no_req", req_count - req_before, 0);
        chk("stall_no_valid", vlog_i.size(), 3);
        mem_lat = 2;
        tick(0, 0, 0);
        chk("stall_release_valid", fetch_valid, 1);
        chk("stall_instr", vlog_i[3], 32'h1111_000C);
        chk("stall_pcn", vlog_p[3], 32'h10);

        a_before = alog.size();
        tick(0, 1, 32'h0000_0103);
        chk("flush_same_cycle", is_flush, 1);
        mem_lat = 0;
        repeat (3) tick(0, 0, 0);
        chk("redir_one_req", alog.size(), a_before + 1);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        chk("redir_dropped", vlog_i.size(), 4);

        tick(1, 0, 0);
        tick(1, 1, 32'h0000_0200);
        tick(0, 1, 32'h0000_0300);
        chk("hold_redir_addr", imem_addr, 32'h0000_0200);
        chk("hold_redir_valid", fetch_valid, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("req_redir_addr", imem_addr, 32'h0000_0300);
        mem_lat = 3;
        tick(0, 1, 32'h0000_0404);
        tick(0, 0, 0);
        chk("wait_rv_redir_addr", imem_addr, 32'h0000_0404);
        chk("redir_no_valid", vlog_i.size(), 4);

        tick(0, 0, 0);
        rst_drv = 0;
        repeat (2) tick(0, 0, 0);
        rst_drv = 1; force_rv = 1; mem_lat = 0;
        v_before = vlog_i.size();
        tick(0, 0, 0);
        chk("post_rst_addr", imem_addr, 32'h0);
        repeat (2) tick(0, 0, 0);
        chk("post_rst_one_valid", vlog_i.size(), v_before + 1);
        chk("post_rst_instr", instruction, 32'h1111_0000);

        chk("wrap_first_pcn", w_first_pcn, 32'h0);
        chk("wrap_second_addr", w_second_addr, 32'h0);

        k = 0;
        while (!imem_req && k < 10) begin tick(0, 0, 0); k++; end
        chk("align_req", imem_req, 1);
        mem_silent = 1; mp_valid = 0;
        pre_err = 0;
        repeat (300) begin
            tick(0, 0, 0);
            if (!fetch_err) pre_err++;
        end
`ifdef KIM_IF_FETCH_TIMEOUT_EN
        chk("timeout_cycles", pre_err, 255);
        chk("timeout_sticky", fetch_err, 1);
`else
        chk("no_timeout_cycles", pre_err, 300);
        chk("no_timeout_err", fetch_err, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
